// File: rtl/cga_mutation.sv
// Mutation stage of the Cartesian Genetic Algorithm engine.
// For every non-parent slot of the population held in external asynchronous
// SRAM, the block reads the parent chromosome, flips howGrowUp pseudo-random
// bits and writes the child back. LEDR rises once every child is regenerated.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   LEDR              done flag, held until reset
//   SRAM_ADDRESS_O    SRAM word address
//   SRAM_DATA_IO      SRAM data bus, driven only during write strobe and hold
//   SRAM_UB_N_O/LB_N  byte enables, tied active
//   SRAM_WE_N_O       write enable, active low
//   SRAM_CE_N_O       chip enable, active low
//   SRAM_OE_N_O       output enable, active low
module cga_mutation #(
  parameter int unsigned geneBit              = 80,
  parameter int unsigned row                  = 3,
  parameter int unsigned column               = 3,
  parameter int unsigned selBit               = 4,
  parameter int unsigned funcBit              = 2,
  parameter int unsigned funcCount            = 4,
  parameter int unsigned geneResultBit        = 2,
  parameter int unsigned primaryInputCount    = 8,
  parameter int unsigned population           = 24,
  parameter int unsigned bestCount            = 4,
  parameter int unsigned maxSupport           = 128,
  parameter int unsigned bitCountMutate       = 7,
  parameter int unsigned mutationMaskCount    = 16,
  parameter int unsigned primaryInputBit      = 3,
  parameter int unsigned howGrowUp            = 4,
  parameter int unsigned funcResultBit        = 4,
  parameter int unsigned mutateCountSelectBit = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        LEDR,
  output logic [19:0] SRAM_ADDRESS_O,
  inout  wire  [15:0] SRAM_DATA_IO,
  output logic        SRAM_UB_N_O,
  output logic        SRAM_LB_N_O,
  output logic        SRAM_WE_N_O,
  output logic        SRAM_CE_N_O,
  output logic        SRAM_OE_N_O
);

  localparam int unsigned WORDS    = (geneBit + 15) / 16;
  localparam int unsigned BUFW     = WORDS * 16;
  localparam int unsigned CHILDREN = population - bestCount;
  // Child counter sized from the population itself so it can always reach it.
  localparam int unsigned CW       = $clog2(population + 1);
  localparam int unsigned WW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned MW       = (howGrowUp > 1) ? $clog2(howGrowUp) : 1;

  localparam logic [BUFW-1:0] VALID_MASK = {BUFW{1'b1}} >> (BUFW - geneBit);
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right shifting).
  localparam logic [mutationMaskCount-1:0] LFSR_TAPS = mutationMaskCount'(32'h0000_B400);
  localparam logic [mutationMaskCount-1:0] LFSR_SEED = mutationMaskCount'(32'h0000_ACE1);

  // Grid/encoding parameters describe the CGP genome layout only.
  logic unused_params;
  assign unused_params = ^(32'(row + column + selBit + funcBit + funcCount + geneResultBit +
                              primaryInputCount + maxSupport + primaryInputBit +
                              funcResultBit + mutateCountSelectBit));

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MUTATE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic                            phase_q, phase_d;
  logic [WW-1:0]                   word_q, word_d;
  logic [MW-1:0]                   mut_q, mut_d;
  logic [CW-1:0]                   child_q, child_d;
  logic [mutationMaskCount-1:0]    lfsr_q, lfsr_d;
  logic [WORDS-1:0][15:0]          buf_q, buf_d;

  logic [19:0] addr_q, addr_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        led_q, led_d;
  logic        drive_q, drive_d;
  logic [15:0] wdata_q, wdata_d;

  logic [bitCountMutate-1:0] idx_raw;
  logic [bitCountMutate-1:0] idx;

  function automatic logic [19:0] chrom_addr(input int unsigned slot, input int unsigned w);
    return 20'(slot * WORDS + w);
  endfunction

  // Folded bit index for this cycle's flip.
  always_comb begin
    idx_raw = lfsr_q[bitCountMutate-1:0];
    idx     = (32'(idx_raw) >= geneBit) ? bitCountMutate'(32'(idx_raw) - geneBit) : idx_raw;
  end

  // Next-state logic, then output decode from the next state so outputs are registered.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    word_d  = word_q;
    mut_d   = mut_q;
    child_d = child_q;
    buf_d   = buf_q;
    lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

    unique case (state_q)
      S_IDLE: begin
        state_d = S_READ;
        phase_d = 1'b0;
        word_d  = '0;
        child_d = '0;
      end
      S_READ: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          buf_d         = buf_q;
          buf_d[word_q] = SRAM_DATA_IO;
          buf_d         = buf_d & VALID_MASK;
          phase_d       = 1'b0;
          if (word_q == WW'(WORDS - 1)) begin
            word_d  = '0;
            mut_d   = '0;
            state_d = S_MUTATE;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      S_MUTATE: begin
        buf_d = buf_q ^ (BUFW'(1) << idx);
        if (mut_q == MW'(howGrowUp - 1)) begin
          state_d = S_WRITE;
          word_d  = '0;
          phase_d = 1'b0;
        end else begin
          mut_d = mut_q + MW'(1);
        end
      end
      S_WRITE: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (word_q == WW'(WORDS - 1)) begin
            word_d  = '0;
            child_d = child_q + CW'(1);
            state_d = (32'(child_q) + 1 == CHILDREN) ? S_DONE : S_READ;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    addr_d  = addr_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    led_d   = 1'b0;
    drive_d = 1'b0;
    wdata_d = wdata_q;

    unique case (state_d)
      S_READ: begin
        addr_d = chrom_addr(32'(child_d) % bestCount, 32'(word_d));
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_WRITE: begin
        // Phase A strobes WE_N; phase B releases it while keeping data on the bus.
        addr_d  = chrom_addr(bestCount + 32'(child_d), 32'(word_d));
        ce_n_d  = 1'b0;
        we_n_d  = phase_d;
        drive_d = 1'b1;
        wdata_d = buf_d[word_d];
      end
      S_DONE:  led_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      word_q  <= '0;
      mut_q   <= '0;
      child_q <= '0;
      lfsr_q  <= LFSR_SEED;
      buf_q   <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      led_q   <= 1'b0;
      drive_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      word_q  <= word_d;
      mut_q   <= mut_d;
      child_q <= child_d;
      lfsr_q  <= lfsr_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      led_q   <= led_d;
      drive_q <= drive_d;
      wdata_q <= wdata_d;
    end
  end

  assign SRAM_DATA_IO   = drive_q ? wdata_q : 16'bz;
  assign LEDR           = led_q;
  assign SRAM_ADDRESS_O = addr_q;
  assign SRAM_CE_N_O    = ce_n_q;
  assign SRAM_OE_N_O    = oe_n_q;
  assign SRAM_WE_N_O    = we_n_q;
  assign SRAM_UB_N_O    = 1'b0;
  assign SRAM_LB_N_O    = 1'b0;

endmodule

// File: tb/tb_cga_mutation.sv
// Directed bench for cga_mutation with an asynchronous SRAM model and a bus monitor.
module tb_cga_mutation;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LEDR;
  logic [19:0] SRAM_ADDRESS_O;
  wire  [15:0] SRAM_DATA_IO;
  logic        SRAM_UB_N_O, SRAM_LB_N_O, SRAM_WE_N_O, SRAM_CE_N_O, SRAM_OE_N_O;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:127];
  logic        sram_oe;
  logic [15:0] mem_rd;

  int wr_count;
  int written [0:127];
  int viol_we_oe;
  int viol_range;
  int viol_bus;
  logic prev_we_n;

  cga_mutation dut (
    .clk            (clk),
    .rst            (rst),
    .LEDR           (LEDR),
    .SRAM_ADDRESS_O (SRAM_ADDRESS_O),
    .SRAM_DATA_IO   (SRAM_DATA_IO),
    .SRAM_UB_N_O    (SRAM_UB_N_O),
    .SRAM_LB_N_O    (SRAM_LB_N_O),
    .SRAM_WE_N_O    (SRAM_WE_N_O),
    .SRAM_CE_N_O    (SRAM_CE_N_O),
    .SRAM_OE_N_O    (SRAM_OE_N_O)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM read path.
  assign sram_oe      = !SRAM_CE_N_O && !SRAM_OE_N_O && SRAM_WE_N_O;
  assign mem_rd       = mem[SRAM_ADDRESS_O[6:0]];
  assign SRAM_DATA_IO = sram_oe ? mem_rd : 16'bz;

  // True when no bit of the bus is actively high (undriven reads as Z or 0).
  function automatic bit bus_quiet(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i] === 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  // SRAM write capture plus protocol monitor; counters clear while in reset.
  always @(posedge clk) begin
    if (rst) begin
      wr_count   = 0;
      viol_we_oe = 0;
      viol_range = 0;
      viol_bus   = 0;
      prev_we_n  = 1'b1;
      for (int i = 0; i < 128; i++) written[i] = 0;
    end else begin
      if (!SRAM_WE_N_O && !SRAM_OE_N_O) viol_we_oe++;
      if (!SRAM_CE_N_O && SRAM_ADDRESS_O >= 20'd120) viol_range++;
      if (SRAM_WE_N_O && SRAM_OE_N_O && prev_we_n && !bus_quiet(SRAM_DATA_IO)) viol_bus++;
      if (!SRAM_WE_N_O && !SRAM_CE_N_O) begin
        wr_count++;
        if (SRAM_ADDRESS_O < 20'd20 || SRAM_ADDRESS_O >= 20'd120) viol_range++;
        else written[SRAM_ADDRESS_O[6:0]]++;
        mem[SRAM_ADDRESS_O[6:0]] = SRAM_DATA_IO;
      end
      prev_we_n = SRAM_WE_N_O;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] get_chrom(input int slot);
    logic [79:0] c;
    for (int j = 0; j < 5; j++) c[16*j +: 16] = mem[slot*5 + j];
    return c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ledr"}, 32'(LEDR), 32'd0);
    check({tag, "_ce_n"}, 32'(SRAM_CE_N_O), 32'd1);
    check({tag, "_oe_n"}, 32'(SRAM_OE_N_O), 32'd1);
    check({tag, "_we_n"}, 32'(SRAM_WE_N_O), 32'd1);
    check({tag, "_addr"}, 32'(SRAM_ADDRESS_O), 32'd0);
    check({tag, "_bus_z"}, 32'(bus_quiet(SRAM_DATA_IO)), 32'd1);
  endtask

  // Release reset and follow the run to completion with fixed cycle bounds.
  task automatic run_to_done(input string tag);
    int early;
    early = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_idle_ce_n"}, 32'(SRAM_CE_N_O), 32'd1);
    for (int k = 1; k <= 480; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check({tag, "_first_addr"}, 32'(SRAM_ADDRESS_O), 32'd0);
        check({tag, "_first_ce_n"}, 32'(SRAM_CE_N_O), 32'd0);
        check({tag, "_first_oe_n"}, 32'(SRAM_OE_N_O), 32'd0);
      end
      if (LEDR) early++;
    end
    check({tag, "_ledr_early"}, 32'(early), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_ledr_481"}, 32'(LEDR), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_ledr_stays"}, 32'(LEDR), 32'd1);
    check({tag, "_done_ce_n"}, 32'(SRAM_CE_N_O), 32'd1);
    check({tag, "_done_bus_z"}, 32'(bus_quiet(SRAM_DATA_IO)), 32'd1);
  endtask

  task automatic check_bus_stats(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      if (a >= 20 && a < 120) begin
        if (written[a] != 1) bad++;
      end else if (written[a] != 0) bad++;
    end
    check({tag, "_write_strobes"}, 32'(wr_count), 32'd100);
    check({tag, "_write_map"}, 32'(bad), 32'd0);
    check({tag, "_we_oe_overlap"}, 32'(viol_we_oe), 32'd0);
    check({tag, "_addr_range"}, 32'(viol_range), 32'd0);
    check({tag, "_bus_idle"}, 32'(viol_bus), 32'd0);
  endtask

  initial begin
    logic [79:0] pat;
    logic [79:0] ch;
    int pc;
    int odd;
    int changed;

    // Run 1: parent 1 all ones, other parents zero, children slots pre-filled with junk.
    for (int a = 0; a < 128; a++) mem[a] = 16'h5A5A;
    for (int a = 0; a < 20; a++) mem[a] = (a >= 5 && a < 10) ? 16'hFFFF : 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_ub_n", 32'(SRAM_UB_N_O), 32'd0);
    check("reset_lb_n", 32'(SRAM_LB_N_O), 32'd0);

    run_to_done("run1");
    check_bus_stats("run1");

    odd = 0;
    changed = 0;
    for (int c = 0; c < 20; c++) begin
      ch = get_chrom(4 + c);
      pc = $countones(ch);
      if (pc % 2 != 0) odd++;
      if ((c % 4) == 1) begin
        check($sformatf("map_ones_slot%0d", 4 + c), 32'(pc >= 76), 32'd1);
        if (pc != 80) changed++;
      end else begin
        check($sformatf("map_zero_slot%0d", 4 + c), 32'(pc <= 4), 32'd1);
        if (pc != 0) changed++;
      end
    end
    check("map_even_distance", 32'(odd), 32'd0);
    check("map_some_mutated", 32'(changed > 0), 32'd1);

    // Run 2: common parent pattern, reset in the middle, then a full run.
    rst = 1'b1;
    pat = 80'h0123456789ABCDEF0123;
    for (int a = 0; a < 128; a++) mem[a] = 16'hA5A5;
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 5; j++) mem[p*5 + j] = pat[16*j +: 16];
    repeat (3) @(posedge clk);

    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (5) @(posedge clk);
    #1;
    check("midrst_hold_ce_n", 32'(SRAM_CE_N_O), 32'd1);
    check("midrst_hold_ledr", 32'(LEDR), 32'd0);

    run_to_done("run2");
    check_bus_stats("run2");

    for (int p = 0; p < 4; p++)
      check($sformatf("parent%0d_intact", p), 32'(get_chrom(p) == pat), 32'd1);
    odd = 0;
    for (int c = 0; c < 20; c++) begin
      pc = $countones(get_chrom(4 + c) ^ pat);
      if (pc % 2 != 0) odd++;
      check($sformatf("child%0d_hd_le4", c), 32'(pc <= 4), 32'd1);
    end
    check("child_even_distance", 32'(odd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
